// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - Y86-64 shared constants and pipeline-control types
package y86_pkg;

  localparam logic [3:0] HALT   = 4'd0;
  localparam logic [3:0] NOP    = 4'd1;
  localparam logic [3:0] RRMOVQ = 4'd2;
  localparam logic [3:0] IRMOVQ = 4'd3;
  localparam logic [3:0] RMMOVQ = 4'd4;
  localparam logic [3:0] MRMOVQ = 4'd5;
  localparam logic [3:0] OPQ    = 4'd6;
  localparam logic [3:0] JXX    = 4'd7;
  localparam logic [3:0] CALL   = 4'd8;
  localparam logic [3:0] RET    = 4'd9;
  localparam logic [3:0] PUSHQ  = 4'd10;
  localparam logic [3:0] POPQ   = 4'd11;

  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;

  localparam logic [3:0] RNONE = 4'd15;
  localparam logic [3:0] RSP   = 4'd4;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_STOP = 1'b1
  } ctrl_state_e;

  function automatic logic is_exc(input logic [2:0] stat);
    return (stat == SHLT) || (stat == SADR) || (stat == SINS);
  endfunction

endpackage

// File: rtl/pipe_perf_cnt.sv
// rtl/pipe_perf_cnt.sv - saturating event counter
module pipe_perf_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - Y86-64 hazard control, processor status FSM and perf counters
module pipe_ctrl
  import y86_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       E_dstM,
  input  logic             e_Cnd,
  input  logic [3:0]       M_icode,
  input  logic [2:0]       m_stat,
  input  logic [3:0]       W_icode,
  input  logic [2:0]       W_stat,
  output logic             F_stall,
  output logic             D_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             W_stall,
  output logic             set_cc_ok,
  output logic [2:0]       cpu_stat,
  output logic             halted,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] ret_cnt,
  output logic [CNT_W-1:0] lu_cnt,
  output logic [CNT_W-1:0] mp_cnt
);

  ctrl_state_e state_q, state_d;
  logic [2:0]  cpu_stat_q, cpu_stat_d;

  logic lu, rt, mp, mx, wx, run;

  always_comb begin
    lu = ((E_icode == MRMOVQ) || (E_icode == POPQ)) && (E_dstM != RNONE) &&
         ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    rt = (D_icode == RET) || (E_icode == RET) || (M_icode == RET);
    mp = (E_icode == JXX) && !e_Cnd;
    mx = is_exc(m_stat);
    wx = is_exc(W_stat);
    run = (state_q == ST_RUN);
  end

  always_comb begin
    state_d    = state_q;
    cpu_stat_d = cpu_stat_q;
    if (run && wx) begin
      state_d    = ST_STOP;
      cpu_stat_d = W_stat;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_RUN;
      cpu_stat_q <= SAOK;
    end else begin
      state_q    <= state_d;
      cpu_stat_q <= cpu_stat_d;
    end
  end

  // Reset flush takes priority over the STOP freeze, which overrides the hazard equations.
  always_comb begin
    F_stall   = lu || rt;
    D_stall   = lu;
    D_bubble  = mp || (!lu && rt);
    E_bubble  = mp || lu;
    M_bubble  = mx || wx;
    W_stall   = wx;
    set_cc_ok = (E_icode == OPQ) && !mx && !wx;
    if (reset) begin
      F_stall   = 1'b0;
      D_stall   = 1'b0;
      D_bubble  = 1'b1;
      E_bubble  = 1'b1;
      M_bubble  = 1'b1;
      W_stall   = 1'b0;
      set_cc_ok = 1'b0;
    end else if (!run) begin
      F_stall   = 1'b1;
      D_stall   = 1'b1;
      D_bubble  = 1'b0;
      E_bubble  = 1'b1;
      M_bubble  = 1'b1;
      W_stall   = 1'b1;
      set_cc_ok = 1'b0;
    end
  end

  assign cpu_stat = cpu_stat_q;
  assign halted   = (state_q == ST_STOP);

  pipe_perf_cnt #(.W(CNT_W)) u_cyc_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (run),
    .q     (cyc_cnt)
  );

  pipe_perf_cnt #(.W(CNT_W)) u_ret_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (run && (W_stat == SAOK) && (W_icode != NOP)),
    .q     (ret_cnt)
  );

  pipe_perf_cnt #(.W(CNT_W)) u_lu_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (run && lu),
    .q     (lu_cnt)
  );

  pipe_perf_cnt #(.W(CNT_W)) u_mp_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (run && mp),
    .q     (mp_cnt)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed self-checking bench for pipe_ctrl
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode, W_icode;
  logic        e_Cnd;
  logic [2:0]  m_stat, W_stat;

  logic        F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc_ok, halted;
  logic [2:0]  cpu_stat;
  logic [31:0] cyc_cnt, ret_cnt, lu_cnt, mp_cnt;

  logic        s_F_stall, s_D_stall, s_D_bubble, s_E_bubble, s_M_bubble, s_W_stall;
  logic        s_set_cc_ok, s_halted;
  logic [2:0]  s_cpu_stat;
  logic [3:0]  s_cyc_cnt, s_ret_cnt, s_lu_cnt, s_mp_cnt;

  int errors = 0;
  int checks = 0;

  logic [6:0]  ctl;
  logic [31:0] snap_cyc, snap_ret, snap_lu, snap_mp;

  assign ctl = {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc_ok};

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk(clk), .reset(reset), .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd), .M_icode(M_icode),
    .m_stat(m_stat), .W_icode(W_icode), .W_stat(W_stat),
    .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble), .E_bubble(E_bubble),
    .M_bubble(M_bubble), .W_stall(W_stall), .set_cc_ok(set_cc_ok),
    .cpu_stat(cpu_stat), .halted(halted),
    .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt), .lu_cnt(lu_cnt), .mp_cnt(mp_cnt)
  );

  pipe_ctrl #(.CNT_W(4)) dut_small (
    .clk(clk), .reset(reset), .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd), .M_icode(M_icode),
    .m_stat(m_stat), .W_icode(W_icode), .W_stat(W_stat),
    .F_stall(s_F_stall), .D_stall(s_D_stall), .D_bubble(s_D_bubble), .E_bubble(s_E_bubble),
    .M_bubble(s_M_bubble), .W_stall(s_W_stall), .set_cc_ok(s_set_cc_ok),
    .cpu_stat(s_cpu_stat), .halted(s_halted),
    .cyc_cnt(s_cyc_cnt), .ret_cnt(s_ret_cnt), .lu_cnt(s_lu_cnt), .mp_cnt(s_mp_cnt)
  );

  task automatic idle();
    D_icode = 4'd1; d_srcA = 4'd15; d_srcB = 4'd15;
    E_icode = 4'd1; E_dstM = 4'd15; e_Cnd = 1'b0;
    M_icode = 4'd1; m_stat = 3'd1; W_icode = 4'd1; W_stat = 3'd1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    #1;
    checks++;
    if (ctl !== 7'b0011100) begin
      errors++;
      $display("FAIL reset_ctl actual=%b required=%b", ctl, 7'b0011100);
    end
    tick();
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if ({halted, cpu_stat} !== {1'b0, 3'd1}) begin
      errors++;
      $display("FAIL reset_stat actual=%b/%0d required=0/1", halted, cpu_stat);
    end
    checks++;
    if ({cyc_cnt, ret_cnt, lu_cnt, mp_cnt} !== 128'd0) begin
      errors++;
      $display("FAIL reset_cnt actual=%0d/%0d/%0d/%0d required=0/0/0/0",
               cyc_cnt, ret_cnt, lu_cnt, mp_cnt);
    end
    checks++;
    if (ctl !== 7'b0) begin
      errors++;
      $display("FAIL idle_ctl actual=%b required=%b", ctl, 7'b0);
    end
    tick();
    checks++;
    if (cyc_cnt !== 32'd1) begin
      errors++;
      $display("FAIL cyc_first actual=%0d required=1", cyc_cnt);
    end
  endtask

  task automatic test_load_use();
    idle();
    E_icode = 4'd5; E_dstM = 4'd3; d_srcA = 4'd3;
    #1;
    checks++;
    if (ctl !== 7'b1101000) begin
      errors++;
      $display("FAIL lu_ctl actual=%b required=%b", ctl, 7'b1101000);
    end
    checks++;
    if (lu_cnt !== 32'd0) begin
      errors++;
      $display("FAIL lu_cnt_before actual=%0d required=0", lu_cnt);
    end
    tick();
    checks++;
    if (lu_cnt !== 32'd1) begin
      errors++;
      $display("FAIL lu_cnt_after actual=%0d required=1", lu_cnt);
    end
    d_srcA = 4'd15; d_srcB = 4'd3;
    #1;
    checks++;
    if (ctl !== 7'b1101000) begin
      errors++;
      $display("FAIL lu_srcB_ctl actual=%b required=%b", ctl, 7'b1101000);
    end
    idle();
  endtask

  task automatic test_rnone();
    idle();
    E_icode = 4'd11; E_dstM = 4'd15;
    #1;
    checks++;
    if (ctl !== 7'b0) begin
      errors++;
      $display("FAIL rnone_ctl actual=%b required=%b", ctl, 7'b0);
    end
    tick();
    checks++;
    if (lu_cnt !== 32'd1) begin
      errors++;
      $display("FAIL rnone_lu_cnt actual=%0d required=1", lu_cnt);
    end
  endtask

  task automatic test_ret();
    idle();
    D_icode = 4'd9;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (ctl !== 7'b1010000) begin
        errors++;
        $display("FAIL ret_cycle%0d actual=%b required=%b", i, ctl, 7'b1010000);
      end
      tick();
    end
    E_icode = 4'd5; E_dstM = 4'd3; d_srcA = 4'd3;
    #1;
    checks++;
    if (ctl !== 7'b1101000) begin
      errors++;
      $display("FAIL ret_lu_ctl actual=%b required=%b", ctl, 7'b1101000);
    end
    idle();
  endtask

  task automatic test_mispredict();
    idle();
    E_icode = 4'd7; e_Cnd = 1'b0; M_icode = 4'd9;
    #1;
    checks++;
    if (ctl !== 7'b1011000) begin
      errors++;
      $display("FAIL mp_ctl actual=%b required=%b", ctl, 7'b1011000);
    end
    tick();
    checks++;
    if (mp_cnt !== 32'd1) begin
      errors++;
      $display("FAIL mp_cnt actual=%0d required=1", mp_cnt);
    end
    e_Cnd = 1'b1;
    #1;
    checks++;
    if (ctl !== 7'b1010000) begin
      errors++;
      $display("FAIL taken_ctl actual=%b required=%b", ctl, 7'b1010000);
    end
    idle();
    E_icode = 4'd6;
    #1;
    checks++;
    if (ctl !== 7'b0000001) begin
      errors++;
      $display("FAIL opq_ctl actual=%b required=%b", ctl, 7'b0000001);
    end
    idle();
  endtask

  task automatic test_retire();
    idle();
    W_icode = 4'd6;
    tick();
    tick();
    W_icode = 4'd1;
    tick();
    checks++;
    if (ret_cnt !== 32'd2) begin
      errors++;
      $display("FAIL ret_cnt actual=%0d required=2", ret_cnt);
    end
  endtask

  task automatic test_exception();
    idle();
    E_icode = 4'd6; m_stat = 3'd3;
    #1;
    checks++;
    if (ctl !== 7'b0000100) begin
      errors++;
      $display("FAIL mx_ctl actual=%b required=%b", ctl, 7'b0000100);
    end
    tick();
    m_stat = 3'd1; W_stat = 3'd3; W_icode = 4'd5;
    #1;
    checks++;
    if ({ctl, halted} !== 8'b0000_1100) begin
      errors++;
      $display("FAIL wx_ctl actual=%b required=%b", {ctl, halted}, 8'b00001100);
    end
    tick();
    snap_cyc = cyc_cnt; snap_ret = ret_cnt; snap_lu = lu_cnt; snap_mp = mp_cnt;
    checks++;
    if ({halted, cpu_stat} !== {1'b1, 3'd3}) begin
      errors++;
      $display("FAIL halt_stat actual=%b/%0d required=1/3", halted, cpu_stat);
    end
    checks++;
    if (ctl !== 7'b1101110) begin
      errors++;
      $display("FAIL stop_ctl actual=%b required=%b", ctl, 7'b1101110);
    end
    W_stat = 3'd1; W_icode = 4'd6;
    E_icode = 4'd7; e_Cnd = 1'b0;
    tick();
    tick();
    checks++;
    if ({halted, cpu_stat} !== {1'b1, 3'd3}) begin
      errors++;
      $display("FAIL halt_sticky actual=%b/%0d required=1/3", halted, cpu_stat);
    end
    checks++;
    if ({cyc_cnt, ret_cnt, lu_cnt, mp_cnt} !== {snap_cyc, snap_ret, snap_lu, snap_mp}) begin
      errors++;
      $display("FAIL cnt_frozen actual=%0d/%0d/%0d/%0d required=%0d/%0d/%0d/%0d",
               cyc_cnt, ret_cnt, lu_cnt, mp_cnt, snap_cyc, snap_ret, snap_lu, snap_mp);
    end
    idle();
    reset = 1'b1;
    #1;
    checks++;
    if (ctl !== 7'b0011100) begin
      errors++;
      $display("FAIL stop_reset_ctl actual=%b required=%b", ctl, 7'b0011100);
    end
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if ({halted, cpu_stat, cyc_cnt} !== {1'b1 ^ 1'b1, 3'd1, 32'd0}) begin
      errors++;
      $display("FAIL stop_reset_state actual=%b/%0d/%0d required=0/1/0", halted, cpu_stat, cyc_cnt);
    end
  endtask

  task automatic test_saturation();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    checks++;
    if (s_cyc_cnt !== 4'd15) begin
      errors++;
      $display("FAIL sat_cyc actual=%0d required=15", s_cyc_cnt);
    end
    checks++;
    if (cyc_cnt !== 32'd20) begin
      errors++;
      $display("FAIL wide_cyc actual=%0d required=20", cyc_cnt);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_load_use();
    test_rnone();
    test_ret();
    test_mispredict();
    test_retire();
    test_exception();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
